// File: rtl/sd_source_switch.sv
// Routes one SPI SD master to the physical slot or a mounted virtual image.
// Source changes wait for an idle bus; also drives a stretched activity LED.
module sd_source_switch #(
  parameter int unsigned NUM_IMG     = 2,
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned LED_HOLD    = 1000000,
  localparam int unsigned SW         = $clog2(NUM_IMG + 1)
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [NUM_IMG-1:0] img_mounted,
  input  logic               img_size_nz,
  input  logic               force_phys,
  input  logic               spi_ss,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [NUM_IMG-1:0] vsd_ss,
  output logic               vsd_sck,
  output logic               vsd_mosi,
  input  logic [NUM_IMG-1:0] vsd_miso,
  output logic               SD_CS,
  output logic               SD_SCK,
  output logic               SD_MOSI,
  input  logic               SD_MISO,
  output logic [SW-1:0]      active_src,
  output logic               switch_pulse,
  output logic               drive_led
);

  localparam int unsigned IW = $clog2(IDLE_CYCLES);
  localparam int unsigned LW = $clog2(LED_HOLD + 1);

  typedef enum logic [1:0] {StRun, StWaitIdle, StSwitch} state_e;

  state_e        state;
  logic [SW-1:0] pending_src, pending_d, mount_idx;
  logic          mount_hit;
  logic [IW-1:0] idle_cnt;
  logic [LW-1:0] led_cnt, led_d;

  // Lowest set mount bit wins; force_phys overrides any mount event.
  always_comb begin
    mount_hit = 1'b0;
    mount_idx = '0;
    for (int i = int'(NUM_IMG) - 1; i >= 0; i--) begin
      if (img_mounted[i]) begin
        mount_hit = 1'b1;
        mount_idx = SW'(i + 1);
      end
    end
    pending_d = pending_src;
    if (force_phys) begin
      pending_d = '0;
    end else if (mount_hit) begin
      if (img_size_nz) begin
        pending_d = mount_idx;
      end else if (pending_src == mount_idx) begin
        pending_d = '0;
      end
    end
  end

  always_comb begin
    led_d = led_cnt;
    if (!spi_ss) begin
      led_d = LW'(LED_HOLD);
    end else if (led_cnt != '0) begin
      led_d = led_cnt - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= StRun;
      active_src   <= '0;
      pending_src  <= '0;
      idle_cnt     <= '0;
      led_cnt      <= '0;
      switch_pulse <= 1'b0;
      drive_led    <= 1'b0;
    end else begin
      pending_src  <= pending_d;
      led_cnt      <= led_d;
      drive_led    <= (led_d != '0);
      switch_pulse <= 1'b0;
      unique case (state)
        StRun: begin
          if (pending_src != active_src) begin
            state    <= StWaitIdle;
            idle_cnt <= '0;
          end
        end
        StWaitIdle: begin
          if (pending_src == active_src) begin
            state <= StRun;
          end else if (!spi_ss) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(IDLE_CYCLES - 1)) begin
            state    <= StSwitch;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        StSwitch: begin
          active_src   <= pending_src;
          switch_pulse <= (pending_src != active_src);
          state        <= StRun;
        end
        default: state <= StRun;
      endcase
    end
  end

  // Both sides are parked while in reset and during the switch cycle.
  always_comb begin
    SD_CS    = 1'b1;
    SD_SCK   = 1'b0;
    SD_MOSI  = 1'b0;
    vsd_ss   = '1;
    vsd_sck  = 1'b0;
    vsd_mosi = 1'b0;
    spi_miso = 1'b1;
    if (n_reset && state != StSwitch) begin
      if (active_src == '0) begin
        SD_CS    = spi_ss;
        SD_SCK   = spi_sck;
        SD_MOSI  = spi_mosi;
        spi_miso = SD_MISO;
      end else begin
        vsd_sck  = spi_sck;
        vsd_mosi = spi_mosi;
        for (int i = 0; i < int'(NUM_IMG); i++) begin
          if (active_src == SW'(i + 1)) begin
            vsd_ss[i] = spi_ss;
            spi_miso  = vsd_miso[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_source_switch.sv
// Bench for sd_source_switch: directed scenarios plus random traffic checked
// every cycle against a behavioural model of source selection and LED timing.
module tb_sd_source_switch;

  localparam int NI = 2;
  localparam int IC = 16;
  localparam int LH = 8;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic [NI-1:0] img_mounted = '0;
  logic          img_size_nz = 1'b0;
  logic          force_phys = 1'b0;
  logic          spi_ss = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
  logic          spi_miso;
  logic [NI-1:0] vsd_ss;
  logic          vsd_sck, vsd_mosi;
  logic [NI-1:0] vsd_miso = '0;
  logic          SD_CS, SD_SCK, SD_MOSI;
  logic          SD_MISO = 1'b0;
  logic [1:0]    active_src;
  logic          switch_pulse, drive_led;

  sd_source_switch #(.NUM_IMG(NI), .IDLE_CYCLES(IC), .LED_HOLD(LH)) dut (
    .clk(clk), .n_reset(n_reset), .img_mounted(img_mounted), .img_size_nz(img_size_nz),
    .force_phys(force_phys), .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .vsd_ss(vsd_ss), .vsd_sck(vsd_sck), .vsd_mosi(vsd_mosi),
    .vsd_miso(vsd_miso), .SD_CS(SD_CS), .SD_SCK(SD_SCK), .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO), .active_src(active_src), .switch_pulse(switch_pulse),
    .drive_led(drive_led)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: which source is wanted, which is live, and how many quiet cycles
  // have passed since a wanted/live mismatch was first noticed.
  int  m_pending, m_active, m_quiet, m_led;
  bit  m_seen, m_switch, m_pulse;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_active = 0; m_quiet = 0; m_led = 0;
    m_seen = 0; m_switch = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int old_p, old_a, k;
    old_p = m_pending;
    old_a = m_active;
    m_pulse = 0;
    if (m_switch) begin
      m_active = old_p;
      m_pulse  = (old_p != old_a);
      m_switch = 0;
      m_seen   = 0;
    end else if (old_p != old_a) begin
      if (!m_seen) begin
        m_seen  = 1;
        m_quiet = 0;
      end else if (!spi_ss) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == IC) m_switch = 1;
      end
    end else begin
      m_seen = 0;
    end
    k = -1;
    for (int i = NI - 1; i >= 0; i--) if (img_mounted[i]) k = i;
    if (force_phys) m_pending = 0;
    else if (k >= 0) begin
      if (img_size_nz) m_pending = k + 1;
      else if (old_p == k + 1) m_pending = 0;
    end
    if (!spi_ss) m_led = LH;
    else if (m_led > 0) m_led--;
  endtask

  task automatic check_all();
    logic e_cs, e_sck, e_mosi, e_vsck, e_vmosi, e_miso;
    logic [NI-1:0] e_vss;
    e_cs = 1; e_sck = 0; e_mosi = 0; e_vss = '1; e_vsck = 0; e_vmosi = 0; e_miso = 1;
    if (n_reset && !m_switch) begin
      if (m_active == 0) begin
        e_cs = spi_ss; e_sck = spi_sck; e_mosi = spi_mosi; e_miso = SD_MISO;
      end else begin
        e_vss[m_active-1] = spi_ss;
        e_vsck = spi_sck; e_vmosi = spi_mosi; e_miso = vsd_miso[m_active-1];
      end
    end
    cmp("active_src", 32'(active_src), 32'(m_active));
    cmp("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
    cmp("drive_led", 32'(drive_led), 32'(m_led != 0));
    cmp("SD_CS", 32'(SD_CS), 32'(e_cs));
    cmp("SD_SCK", 32'(SD_SCK), 32'(e_sck));
    cmp("SD_MOSI", 32'(SD_MOSI), 32'(e_mosi));
    cmp("vsd_ss", 32'(vsd_ss), 32'(e_vss));
    cmp("vsd_sck", 32'(vsd_sck), 32'(e_vsck));
    cmp("vsd_mosi", 32'(vsd_mosi), 32'(e_vmosi));
    cmp("spi_miso", 32'(spi_miso), 32'(e_miso));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!n_reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_pulse(input string name, input int exp);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (switch_pulse) seen = 1;
    end
    cmp(name, 32'(n), 32'(exp));
  endtask

  task automatic count_pulses(input string name, input int cycles);
    int p;
    p = 0;
    repeat (cycles) begin
      tick();
      if (switch_pulse) p++;
    end
    cmp(name, 32'(p), 32'd0);
  endtask

  initial begin
    int cnt;
    model_reset();
    @(negedge clk);
    check_all();
    repeat (2) tick();
    n_reset = 1'b1;
    #1;
    cmp("rst_sd_cs_follows", 32'(SD_CS), 32'd1);
    spi_ss = 1'b0;
    #1;
    cmp("rst_sd_cs_low", 32'(SD_CS), 32'd0);
    cmp("rst_vsd_ss", 32'(vsd_ss), 32'b11);
    spi_ss = 1'b1;
    tick();

    // Mount slot 1 on an idle bus.
    img_mounted = 2'b10; img_size_nz = 1'b1;
    tick();
    img_mounted = '0;
    wait_pulse("mount_latency", 18);
    cmp("mount_active", 32'(active_src), 32'd2);
    cmp("mount_sd_cs", 32'(SD_CS), 32'd1);
    spi_ss = 1'b0; vsd_miso = 2'b10;
    #1;
    cmp("mount_vsd_ss", 32'(vsd_ss), 32'b01);
    cmp("mount_miso", 32'(spi_miso), 32'd1);
    spi_ss = 1'b1;
    tick();
    cmp("pulse_one_cycle", 32'(switch_pulse), 32'd0);

    // Unmounting a slot that is not pending changes nothing.
    img_mounted = 2'b01; img_size_nz = 1'b0;
    tick();
    img_mounted = '0;
    count_pulses("unmount_other_pulses", 25);
    cmp("unmount_other_active", 32'(active_src), 32'd2);

    // Unmounting the live slot falls back to physical.
    img_mounted = 2'b10; img_size_nz = 1'b0;
    tick();
    img_mounted = '0;
    wait_pulse("unmount_latency", 18);
    cmp("unmount_active", 32'(active_src), 32'd0);

    // force_phys beats a simultaneous mount.
    force_phys = 1'b1; img_mounted = 2'b01; img_size_nz = 1'b1;
    tick();
    img_mounted = '0;
    count_pulses("force_pulses", 25);
    cmp("force_active", 32'(active_src), 32'd0);
    force_phys = 1'b0;
    tick();

    // Busy bus holds off the switch; a glitch restarts the idle count.
    spi_ss = 1'b0; img_mounted = 2'b01; img_size_nz = 1'b1;
    tick();
    img_mounted = '0;
    count_pulses("busy_pulses", 39);
    spi_ss = 1'b1;
    repeat (10) tick();
    spi_ss = 1'b0;
    tick();
    spi_ss = 1'b1;
    wait_pulse("glitch_latency", 17);
    cmp("glitch_active", 32'(active_src), 32'd1);

    // Activity LED stretch.
    repeat (12) tick();
    cmp("led_idle", 32'(drive_led), 32'd0);
    cnt = 0;
    spi_ss = 1'b0;
    tick();
    if (drive_led) cnt++;
    spi_ss = 1'b1;
    repeat (20) begin
      tick();
      if (drive_led) cnt++;
    end
    cmp("led_hold", 32'(cnt), 32'd8);

    // Reset in the middle of an idle wait.
    img_mounted = 2'b10; img_size_nz = 1'b1;
    tick();
    img_mounted = '0;
    repeat (5) tick();
    n_reset = 1'b0;
    #1;
    model_reset();
    check_all();
    cmp("rst_mid_vsd_ss", 32'(vsd_ss), 32'b11);
    cmp("rst_mid_sd_cs", 32'(SD_CS), 32'd1);
    cmp("rst_mid_active", 32'(active_src), 32'd0);
    repeat (2) tick();
    n_reset = 1'b1;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) spi_ss = ~spi_ss;
      spi_sck     = 1'($urandom);
      spi_mosi    = 1'($urandom);
      SD_MISO     = 1'($urandom);
      vsd_miso    = NI'($urandom);
      img_mounted = ($urandom_range(0, 29) == 0) ? NI'($urandom) : '0;
      img_size_nz = ($urandom_range(0, 3) != 0);
      force_phys  = ($urandom_range(0, 99) < 3);
      n_reset     = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
